if_prefetch_buffer: RTL and testbench
=====================================

// Module: if_prefetch_buffer
// PURPOSE
//  Instruction prefetch unit between the processor IF stage and the tagged instruction memory (IM).
//  Issues sequential BUS_LOAD requests and tracks outstanding memory tags in order.
//  Buffers returned instructions with their PC/NPC in a FIFO that the IF stage drains via valid/ready.
//  A redirect (taken branch) flushes the buffer and discards in-flight responses.
// PARAMETERS
//  DEPTH     4   instruction FIFO entries; also max outstanding requests (power of 2, 2..8)
//  RESET_PC  0   fetch address after reset
// PORTS
//  clk              in   1   clock, all state updates on posedge
//  rst              in   1   synchronous reset, active-low
//  redirect_en      in   1   flush and restart fetch at redirect_pc
//  redirect_pc      in   32  new fetch address (word aligned)
//  deq_ready        in   1   IF stage accepts head instruction this cycle
//  inst_valid       out  1   FIFO head valid
//  inst_out         out  32  head instruction word
//  inst_pc          out  32  head PC
//  inst_npc         out  32  head PC+4
//  proc2mem_addr    out  32  IM request address
//  proc2mem_command out  2   BUS_NONE=2'b00, BUS_LOAD=2'b01 (BUS_STORE never driven)
//  mem2proc_response in  4   tag granted to this cycle's request; 0 = rejected
//  mem2proc_data    in   32  returned instruction word
//  mem2proc_tag     in   4   tag of returning data; 0 = no data
//  tag_err          out  1   sticky: returned tag does not match oldest outstanding tag
// BEHAVIOUR
//  Reset (rst==0 at posedge): fetch_pc<=RESET_PC; FIFO and outstanding queue empty; tag_err<=0.
//   Outputs during/after reset: inst_valid=0, proc2mem_command=BUS_NONE, inst_*=0.
//  Issue: command=BUS_LOAD, addr=fetch_pc when rst==1, redirect_en==0 and
//   fifo_count + outstanding_count < DEPTH (dead entries count). Otherwise BUS_NONE, addr=0.
//   Command/addr are combinational from registered state.
//  Grant: LOAD with response!=0 -> push {tag=response, pc=fetch_pc, live=1} to outstanding queue,
//   fetch_pc<=fetch_pc+4 (32-bit wrap). response==0 -> retry same address next cycle.
//  Return: tag!=0 and equals outstanding head tag -> pop head; if live, push
//   {data, pc, pc+4} into FIFO; if dead, discard. Credit rule guarantees FIFO never overflows.
//   tag!=0 with empty queue or mismatched head -> tag_err<=1, data dropped, queue unchanged.
//  Dequeue: inst_valid && deq_ready -> pop FIFO head. Head outputs are registered-state driven
//   (first valid one cycle after the return edge; 0-cycle bypass not permitted).
//  Simultaneous push/pop on FIFO and outstanding queue in same cycle: both occur; counts unchanged.
//  Redirect (redirect_en==1 at posedge): FIFO emptied; all outstanding entries marked dead,
//   including a grant in the same cycle (none issued, since command is BUS_NONE);
//   fetch_pc<=redirect_pc; return in the same cycle is processed as dead. deq_ready ignored.
//   inst_valid=0 next cycle; new LOAD issued the cycle after redirect if credit allows.
//  Reset mid-operation: all state cleared; late tags afterwards hit empty queue -> tag_err
//   (bench must drain memory before releasing reset or mask tag_err).
//  Latency: grant at cycle N, data return at M>N -> inst_valid at M+1.
//  Order: instructions delivered strictly in fetch-address order; no duplicates, no gaps.
// TESTING
//  1 Reset: rst=0 for 2 cycles -> inst_valid=0, command=BUS_NONE; release -> LOAD addr 0x0.
//  2 Streaming: mem grants tags 1,2,3,4, returns in order, deq_ready=1 -> inst_pc 0x0,0x4,0x8,0xC,
//    inst_npc 0x4..0x10, data matches testshex words.
//  3 Backpressure: deq_ready=0, DEPTH=4 -> exactly 4 LOADs issued, then BUS_NONE until a dequeue;
//    one dequeue -> one new LOAD next cycle.
//  4 Rejection: response=0 for 3 cycles at addr 0x8 -> addr stays 0x8, advances to 0xC after grant.
//  5 Redirect: 2 outstanding (pc 0x10,0x14), redirect_pc=0x100 -> their returns discarded,
//    first delivered inst_pc=0x100, no tag_err.
//  6 Bad tag: return tag 7 while head tag 3 -> tag_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/if_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// if_prefetch_buffer
//
// Instruction prefetch unit between the IF stage and a tagged instruction
// memory. It issues sequential BUS_LOAD requests, keeps the granted tags in
// an in-order outstanding queue, and buffers returned words with their
// PC/NPC in a FIFO that the IF stage drains.
//
// Handshake: an instruction is transferred on a rising clock edge where
// inst_valid && deq_ready are both 1. inst_valid and the inst_* head
// outputs come only from registered state. A word written into the FIFO on
// edge M is first visible after edge M, so there is no same-cycle bypass.
// Once inst_valid rises it stays high until the head is taken or a redirect
// flushes the buffer. deq_ready is ignored in a redirect cycle.
//
// Ports
//   clk               clock, all state updates on posedge
//   rst               synchronous reset, active-low
//   redirect_en       flush and restart fetch at redirect_pc
//   redirect_pc       new fetch address (word aligned)
//   deq_ready         IF stage accepts the head instruction this cycle
//   inst_valid        FIFO head valid
//   inst_out          head instruction word (0 when not valid)
//   inst_pc           head PC (0 when not valid)
//   inst_npc          head PC+4 (0 when not valid)
//   proc2mem_addr     IM request address (0 when no request)
//   proc2mem_command  BUS_NONE=2'b00 / BUS_LOAD=2'b01
//   mem2proc_response tag granted to this cycle's request, 0 = rejected
//   mem2proc_data     returned instruction word
//   mem2proc_tag      tag of returning data, 0 = no data
//   tag_err           sticky: returned tag did not match oldest outstanding
// ---------------------------------------------------------------------------
module if_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        deq_ready,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_npc,
    output logic [31:0] proc2mem_addr,
    output logic [1:0]  proc2mem_command,
    input  logic [3:0]  mem2proc_response,
    input  logic [31:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic        tag_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t         PTR_ONE  = ptr_t'(1);
    localparam cnt_t         CNT_ONE  = cnt_t'(1);
    localparam logic [CW:0]  DEPTH_W  = (CW + 1)'(DEPTH);
    localparam logic [1:0]   BUS_NONE = 2'b00;
    localparam logic [1:0]   BUS_LOAD = 2'b01;

    // Fetch address of the next request.
    logic [31:0] fetch_pc;

    // Outstanding request queue, oldest entry at osq_head.
    logic [3:0]       osq_tag [DEPTH];
    logic [31:0]      osq_pc  [DEPTH];
    logic [DEPTH-1:0] osq_live;
    ptr_t             osq_head, osq_tail;
    cnt_t             osq_count;

    // Instruction FIFO.
    logic [31:0] fifo_data [DEPTH];
    logic [31:0] fifo_pc   [DEPTH];
    ptr_t        fifo_head, fifo_tail;
    cnt_t        fifo_count;

    logic        tag_err_q;

    logic [CW:0] credit_used;
    logic        issue;
    logic        grant;
    logic        ret_valid;
    logic        ret_match;
    logic        ret_bad;
    logic        fifo_push;
    logic        fifo_pop;

    // Every outstanding request, live or dead, holds a FIFO slot in reserve,
    // so a returning live word always finds room.
    assign credit_used = {1'b0, fifo_count} + {1'b0, osq_count};
    assign issue       = rst && !redirect_en && (credit_used < DEPTH_W);
    assign grant       = issue && (mem2proc_response != 4'd0);

    assign ret_valid   = (mem2proc_tag != 4'd0);
    assign ret_match   = ret_valid && (osq_count != '0) &&
                         (osq_tag[osq_head] == mem2proc_tag);
    assign ret_bad     = ret_valid && !ret_match;

    // A return landing in a redirect cycle belongs to the old path.
    assign fifo_push   = ret_match && osq_live[osq_head] && !redirect_en;
    assign fifo_pop    = inst_valid && deq_ready && !redirect_en;

    assign proc2mem_command = issue ? BUS_LOAD : BUS_NONE;
    assign proc2mem_addr    = issue ? fetch_pc : 32'h0;

    assign inst_valid = (fifo_count != '0);
    assign inst_out   = inst_valid ? fifo_data[fifo_head]         : 32'h0;
    assign inst_pc    = inst_valid ? fifo_pc[fifo_head]           : 32'h0;
    assign inst_npc   = inst_valid ? (fifo_pc[fifo_head] + 32'd4) : 32'h0;
    assign tag_err    = tag_err_q;

    // Control state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            osq_live   <= '0;
            osq_head   <= '0;
            osq_tail   <= '0;
            osq_count  <= '0;
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_count <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            // Outstanding queue.
            if (grant) begin
                osq_live[osq_tail] <= 1'b1;
                osq_tail           <= osq_tail + PTR_ONE;
                fetch_pc           <= fetch_pc + 32'd4;
            end
            if (ret_match) begin
                osq_head <= osq_head + PTR_ONE;
            end
            case ({grant, ret_match})
                2'b10:   osq_count <= osq_count + CNT_ONE;
                2'b01:   osq_count <= osq_count - CNT_ONE;
                default: osq_count <= osq_count;
            endcase

            // Redirect kills every request still in flight; they keep their
            // queue slots so their returns are matched and then discarded.
            if (redirect_en) begin
                osq_live <= '0;
                fetch_pc <= redirect_pc;
            end

            // Instruction FIFO.
            if (redirect_en) begin
                fifo_head  <= '0;
                fifo_tail  <= '0;
                fifo_count <= '0;
            end else begin
                if (fifo_push) begin
                    fifo_tail <= fifo_tail + PTR_ONE;
                end
                if (fifo_pop) begin
                    fifo_head <= fifo_head + PTR_ONE;
                end
                case ({fifo_push, fifo_pop})
                    2'b10:   fifo_count <= fifo_count + CNT_ONE;
                    2'b01:   fifo_count <= fifo_count - CNT_ONE;
                    default: fifo_count <= fifo_count;
                endcase
            end

            if (ret_bad) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    // Payload storage; entries are only read while their counters say they
    // are occupied, so they need no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            osq_tag[osq_tail] <= mem2proc_response;
            osq_pc[osq_tail]  <= fetch_pc;
        end
        if (rst && fifo_push) begin
            fifo_data[fifo_tail] <= mem2proc_data;
            fifo_pc[fifo_tail]   <= osq_pc[osq_head];
        end
    end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
module tb_if_prefetch_buffer;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        deq_ready;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_npc;
    logic [31:0] proc2mem_addr;
    logic [1:0]  proc2mem_command;
    logic [3:0]  mem2proc_response;
    logic [31:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic        tag_err;

    int n_cmp = 0;
    int n_err = 0;

    if_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_en       (redirect_en),
        .redirect_pc       (redirect_pc),
        .deq_ready         (deq_ready),
        .inst_valid        (inst_valid),
        .inst_out          (inst_out),
        .inst_pc           (inst_pc),
        .inst_npc          (inst_npc),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_command  (proc2mem_command),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .tag_err           (tag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        deq;
        logic [3:0]  resp;
        logic [3:0]  rtag;
        logic [31:0] rdata;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] data;
        logic        terr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_i, input logic redir, input logic [31:0] rpc,
        input logic deq, input logic [3:0] resp, input logic [3:0] rtag,
        input logic [31:0] rdata, input logic [1:0] cmd, input logic [31:0] addr,
        input logic valid, input logic [31:0] pc, input logic [31:0] data,
        input logic terr);
        vec_t v;
        v.rst = rst_i; v.redir = redir; v.rpc = rpc; v.deq = deq;
        v.resp = resp; v.rtag = rtag; v.rdata = rdata;
        v.cmd = cmd; v.addr = addr; v.valid = valid; v.pc = pc;
        v.data = data; v.terr = terr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                               input logic valid, input logic [31:0] pc,
                               input logic [31:0] data, input logic terr);
        logic [31:0] npc;
        npc = valid ? pc + 32'd4 : 32'h0;
        chk({tag, " cmd"},   {30'h0, proc2mem_command}, {30'h0, cmd});
        chk({tag, " addr"},  proc2mem_addr, addr);
        chk({tag, " valid"}, {31'h0, inst_valid}, {31'h0, valid});
        chk({tag, " pc"},    inst_pc, pc);
        chk({tag, " npc"},   inst_npc, npc);
        chk({tag, " data"},  inst_out, data);
        chk({tag, " terr"},  {31'h0, tag_err}, {31'h0, terr});
    endtask

    initial begin
        rst = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0;
        mem2proc_response = 4'd0; mem2proc_data = 32'h0; mem2proc_tag = 4'd0;

        //          rst redir rpc        deq resp rtag rdata          cmd   addr      v  pc        data          terr
        // reset held, then release
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        NONE, 32'h0,   0, 32'h0,   32'h0,        0));
        // streaming with one early dequeue stall; rejections at 0x8 for 3 cycles
        vecs.push_back(mk(1, 0, 32'h0,   0, 1, 0, 32'h0,        LOAD, 32'h0,   0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 2, 0, 32'h0,        LOAD, 32'h4,   0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 1, 32'h10000000, LOAD, 32'h8,   0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,        LOAD, 32'h8,   1, 32'h0,   32'h10000000, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 2, 32'h10000004, LOAD, 32'h8,   1, 32'h0,   32'h10000000, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 3, 0, 32'h0,        LOAD, 32'h8,   1, 32'h4,   32'h10000004, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 4, 0, 32'h0,        LOAD, 32'hC,   0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 3, 32'h10000008, LOAD, 32'h10,  0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 4, 32'h1000000C, LOAD, 32'h10,  1, 32'h8,   32'h10000008, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h0,        LOAD, 32'h10,  1, 32'hC,   32'h1000000C, 0));
        // two in flight (0x10, 0x14), then redirect to 0x100 with tag 5 returning
        vecs.push_back(mk(1, 0, 32'h0,   0, 5, 0, 32'h0,        LOAD, 32'h10,  0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 6, 0, 32'h0,        LOAD, 32'h14,  0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 1, 32'h100, 1, 0, 5, 32'hBAD00010, NONE, 32'h0,   0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 7, 6, 32'hBAD00014, LOAD, 32'h100, 0, 32'h0,   32'h0,        0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 7, 32'h10000100, LOAD, 32'h104, 0, 32'h0,   32'h0,        0));
        // bad tag 7 while head tag is 3
        vecs.push_back(mk(1, 0, 32'h0,   0, 3, 0, 32'h0,        LOAD, 32'h104, 1, 32'h100, 32'h10000100, 0));
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 7, 32'hBAD0BAD0, LOAD, 32'h108, 1, 32'h100, 32'h10000100, 0));
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 3, 32'h10000104, LOAD, 32'h108, 1, 32'h100, 32'h10000100, 1));
        vecs.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h0,        LOAD, 32'h108, 1, 32'h104, 32'h10000104, 1));
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,        LOAD, 32'h108, 0, 32'h0,   32'h0,        1));
        // reset clears the sticky error
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,        NONE, 32'h0,   0, 32'h0,   32'h0,        1));
        vecs.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,        LOAD, 32'h0,   0, 32'h0,   32'h0,        0));

        // Clock/reset: hold reset across two edges before any check.
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst               = vecs[i].rst;
            redirect_en       = vecs[i].redir;
            redirect_pc       = vecs[i].rpc;
            deq_ready         = vecs[i].deq;
            mem2proc_response = vecs[i].resp;
            mem2proc_tag      = vecs[i].rtag;
            mem2proc_data     = vecs[i].rdata;
            #1;
            chk_outputs($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].valid,
                        vecs[i].pc, vecs[i].data, vecs[i].terr);
        end

        // Backpressure: tags 1..4 granted and returned one cycle later with
        // deq_ready low, then a single dequeue frees exactly one credit.
        for (int c = 0; c < 12; c++) begin
            logic [1:0]  e_cmd;
            logic [31:0] e_addr;
            logic        e_valid;
            logic [31:0] e_pc;
            @(negedge clk);
            rst               = 1'b1;
            redirect_en       = 1'b0;
            redirect_pc       = 32'h0;
            deq_ready         = (c == 9);
            mem2proc_response = (c < 4) ? 4'(c + 1) : ((c == 10) ? 4'd5 : 4'd0);
            mem2proc_tag      = (c >= 1 && c <= 4) ? 4'(c) : 4'd0;
            mem2proc_data     = 32'h10000000 + 32'((c - 1) * 4);
            #1;
            e_cmd   = (c < 4 || c == 10) ? LOAD : NONE;
            e_addr  = (c < 4) ? 32'(c * 4) : ((c == 10) ? 32'h10 : 32'h0);
            e_valid = (c >= 2);
            e_pc    = (c >= 10) ? 32'h4 : 32'h0;
            chk_outputs($sformatf("bp%0d", c), e_cmd, e_addr, e_valid,
                        e_valid ? e_pc : 32'h0,
                        e_valid ? 32'h10000000 + e_pc : 32'h0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
